// File: rtl/pc_gen_pkg.sv
// Shared configuration for the fetch PC generator: stall vector width,
// enable/disable encodings, the zero word, the next-PC source select
// and a helper for the fetch-group offset width.
package pc_gen_pkg;

  localparam int StallLen = 6;
  localparam logic Enable = 1'b1;
  localparam logic Disable = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Where the next fetch address comes from when state is allowed to move
  typedef enum logic [1:0] {
    SEL_SEQ     = 2'd0,
    SEL_TARGET  = 2'd1,
    SEL_RAS     = 2'd2,
    SEL_CORRECT = 2'd3
  } pc_sel_e;

  // Number of byte-offset bits inside one fetch group of 32-bit instructions
  function automatic int groupShift(input int fetchWidth);
    return $clog2(4 * fetchWidth);
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Return-address stack for the fetch PC generator. A circular buffer whose
// pointer names the next free slot; when full, a push overwrites the oldest
// entry. Push together with pop replaces the top entry (return-then-call).
module ras_stack
  import pc_gen_pkg::*;
#(
  parameter int ADDR_LEN  = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic                flush_i,
  input  logic [ADDR_LEN-1:0] push_data_i,
  output logic [ADDR_LEN-1:0] top_o,
  output logic                empty_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_LEN-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    topIdx;
  logic [PTR_W-1:0]    wrIdx;
  logic                wrEn;

  assign topIdx  = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[topIdx];
  assign empty_o = (count_q == '0);

  // Decide pointer/count movement and which slot (if any) gets written
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wrEn    = Disable;
    wrIdx   = ptr_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push_i && pop_i) begin
      wrEn = Enable;
      if (empty_o) begin
        wrIdx   = ptr_q;
        ptr_d   = ptr_q + PTR_W'(1);
        count_d = CNT_W'(1);
      end else begin
        wrIdx = topIdx;
      end
    end else if (push_i) begin
      wrEn  = Enable;
      wrIdx = ptr_q;
      ptr_d = ptr_q + PTR_W'(1);
      if (count_q != FULL_CNT) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop_i && !empty_o) begin
      ptr_d   = topIdx;
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset empties the stack
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never cleared; reset only suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && wrEn) begin
      mem_q[wrIdx] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: picks the next fetch-group address from reset,
// misprediction redirect, predicted target / return-address stack, or the
// next sequential group, and reports which slots of the group are valid.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int ADDR_LEN    = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = '0,
  parameter int FETCH_WIDTH = 1,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [StallLen-1:0]    stall,
  input  logic                   jump_mistake,
  input  logic [ADDR_LEN-1:0]    correct_target,
  input  logic                   jump_predict,
  input  logic [ADDR_LEN-1:0]    predict_target,
  input  logic                   predict_call,
  input  logic                   predict_ret,
  input  logic [ADDR_LEN-1:0]    predict_link,
  output logic [ADDR_LEN-1:0]    pc,
  output logic [FETCH_WIDTH-1:0] slot_valid,
  output logic                   jump,
  output logic                   ras_empty
);

  localparam int SHIFT = groupShift(FETCH_WIDTH);
  localparam logic [ADDR_LEN-1:0] GROUP_BYTES = ADDR_LEN'(4 * FETCH_WIDTH);
  localparam logic [ADDR_LEN-1:0] GROUP_MASK  = GROUP_BYTES - ADDR_LEN'(1);

  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic                jump_q, jump_d;
  logic [ADDR_LEN-1:0] seqPc;
  logic [ADDR_LEN-1:0] rasTop;
  logic                rasEmpty;
  logic                advanceOk;
  logic                holdState;
  logic                rasPush, rasPop, rasFlush;
  pc_sel_e             pcSel;
  logic                unusedStall;

  // Only the fetch-stage stall bit matters to this block
  assign unusedStall = ^stall[StallLen-1:1];

  assign seqPc     = (pc_q & ~GROUP_MASK) + GROUP_BYTES;
  assign holdState = !rdy || (!jump_mistake && stall[0]);
  assign advanceOk = rdy && !jump_mistake && !stall[0];
  assign rasFlush  = rdy && jump_mistake;
  assign rasPush   = advanceOk && jump_predict && predict_call;
  assign rasPop    = advanceOk && jump_predict && predict_ret;

  // Choose the next-PC source by redirect/prediction priority
  always_comb begin
    pcSel = SEL_SEQ;
    if (jump_mistake) begin
      pcSel = SEL_CORRECT;
    end else if (jump_predict) begin
      pcSel = (predict_ret && !rasEmpty) ? SEL_RAS : SEL_TARGET;
    end
  end

  // Form next PC and jump flag; a frozen pipeline keeps both unchanged
  always_comb begin
    pc_d   = pc_q;
    jump_d = jump_q;
    if (!holdState) begin
      case (pcSel)
        SEL_CORRECT: begin pc_d = correct_target; jump_d = Disable; end
        SEL_RAS:     begin pc_d = rasTop;         jump_d = Enable;  end
        SEL_TARGET:  begin pc_d = predict_target; jump_d = Enable;  end
        default:     begin pc_d = seqPc;          jump_d = Disable; end
      endcase
    end
  end

  // PC and jump registers with synchronous reset taking precedence over rdy
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      jump_q <= Disable;
    end else begin
      pc_q   <= pc_d;
      jump_q <= jump_d;
    end
  end

  ras_stack #(
    .ADDR_LEN  (ADDR_LEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rasPush),
    .pop_i       (rasPop),
    .flush_i     (rasFlush),
    .push_data_i (predict_link),
    .top_o       (rasTop),
    .empty_o     (rasEmpty)
  );

  // Slots before the entry offset of a mid-group target are not valid
  generate
    if (FETCH_WIDTH == 1) begin : g_single
      assign slot_valid = '1;
    end else begin : g_multi
      localparam int SLOT_W = SHIFT - 2;
      for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
        assign slot_valid[i] = (pc_q[SHIFT-1:2] <= SLOT_W'(i));
      end
    end
  endgenerate

  assign pc        = pc_q;
  assign jump      = jump_q;
  assign ras_empty = rasEmpty;

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen with two-slot fetch groups and a
// four-entry return-address stack.
module tb_pc_gen;
  import pc_gen_pkg::*;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        st0;
    logic        mis;
    logic [31:0] corr;
    logic        jp;
    logic        call;
    logic        ret;
    logic [31:0] tgt;
    logic [31:0] link;
    logic [31:0] expPc;
    logic        expJump;
    logic [1:0]  expSlot;
    logic        expEmpty;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                rdy;
  logic [StallLen-1:0] stall;
  logic                jump_mistake;
  logic [31:0]         correct_target;
  logic                jump_predict;
  logic [31:0]         predict_target;
  logic                predict_call;
  logic                predict_ret;
  logic [31:0]         predict_link;
  logic [31:0]         pc;
  logic [1:0]          slot_valid;
  logic                jump;
  logic                ras_empty;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  pc_gen #(
    .ADDR_LEN    (32),
    .RESET_PC    (32'h0),
    .FETCH_WIDTH (2),
    .RAS_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .stall          (stall),
    .jump_mistake   (jump_mistake),
    .correct_target (correct_target),
    .jump_predict   (jump_predict),
    .predict_target (predict_target),
    .predict_call   (predict_call),
    .predict_ret    (predict_ret),
    .predict_link   (predict_link),
    .pc             (pc),
    .slot_valid     (slot_valid),
    .jump           (jump),
    .ras_empty      (ras_empty)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic rd, input logic s0,
                              input logic m, input logic [31:0] c,
                              input logic j, input logic ca, input logic re,
                              input logic [31:0] t, input logic [31:0] l,
                              input logic [31:0] ep, input logic ej,
                              input logic [1:0] es, input logic ee);
    vec_t v;
    v.rst = r; v.rdy = rd; v.st0 = s0; v.mis = m; v.corr = c;
    v.jp = j; v.call = ca; v.ret = re; v.tgt = t; v.link = l;
    v.expPc = ep; v.expJump = ej; v.expSlot = es; v.expEmpty = ee;
    return v;
  endfunction

  // Drive one vector at the falling edge, let the rising edge capture it
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst            = v.rst;
    rdy            = v.rdy;
    stall          = {5'b10101 & {5{v.st0}}, v.st0};
    jump_mistake   = v.mis;
    correct_target = v.corr;
    jump_predict   = v.jp;
    predict_call   = v.call;
    predict_ret    = v.ret;
    predict_target = v.tgt;
    predict_link   = v.link;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    checks++;
    if (pc !== v.expPc) begin
      failures++;
      $display("[TB] FAIL %s pc: got %h expected %h", name, pc, v.expPc);
    end
    checks++;
    if (jump !== v.expJump) begin
      failures++;
      $display("[TB] FAIL %s jump: got %b expected %b", name, jump, v.expJump);
    end
    checks++;
    if (slot_valid !== v.expSlot) begin
      failures++;
      $display("[TB] FAIL %s slot_valid: got %b expected %b", name, slot_valid, v.expSlot);
    end
    checks++;
    if (ras_empty !== v.expEmpty) begin
      failures++;
      $display("[TB] FAIL %s ras_empty: got %b expected %b", name, ras_empty, v.expEmpty);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; stall = '0; jump_mistake = 1'b0;
    correct_target = '0; jump_predict = 1'b0; predict_target = '0;
    predict_call = 1'b0; predict_ret = 1'b0; predict_link = '0;

    //             rst rdy st mis corr          jp ca re tgt           link          expPc         ej es     ee
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h8,        0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h10,       0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 0, 32'h104,      32'h0,        32'h104,      1, 2'b10, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h108,      0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 0, 32'h200,      32'h40,       32'h200,      1, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 0, 32'h300,      32'h80,       32'h300,      1, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h500,      32'h0,        32'h80,       1, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h500,      32'h0,        32'h40,       1, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h200,      32'h0,        32'h200,      1, 2'b11, 1));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(0, 1, 0, 0, 32'h0,      1, 1, 0, 32'h1000,     32'h10 * k,   32'h1000,     1, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h600,      32'h0,        32'h50,       1, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h600,      32'h0,        32'h40,       1, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h600,      32'h0,        32'h30,       1, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h600,      32'h0,        32'h20,       1, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h600,      32'h0,        32'h600,      1, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 0, 32'h1000,     32'h70,       32'h1000,     1, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 32'h900,      32'h74,       32'h70,       1, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h900,      32'h0,        32'h74,       1, 2'b10, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 32'h904,      32'h88,       32'h904,      1, 2'b10, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0,        32'h88,       1, 2'b11, 1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h88,       1, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h90,       0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 0, 0, 32'h500,      32'h0,        32'h90,       0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 0, 32'h400,      32'h44,       32'h400,      1, 2'b11, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h300,      1, 1, 0, 32'h600,      32'h48,       32'h300,      0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 0, 32'h700,      32'h4c,       32'h700,      1, 2'b11, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h300,      0, 0, 0, 32'h0,        32'h0,        32'h700,      1, 2'b11, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 1, 32'h500,      32'h0,        32'h700,      1, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h500,      32'h0,        32'h4c,       1, 2'b10, 1));
    vecs.push_back(mk(0, 1, 0, 1, 32'hFFFFFFF8, 0, 0, 0, 32'h0,        32'h0,        32'hFFFFFFF8, 0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 1, 32'hFFFFFFFC, 0, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 0, 2'b10, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 0, 32'h700,      32'h4c,       32'h700,      1, 2'b11, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 1, 0, 32'h800,      32'h50,       32'h0,        0, 2'b11, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 32'h500,      32'h0,        32'h500,      1, 2'b11, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 2'b11, 1));

    foreach (vecs[idx]) begin
      applyStimulus(vecs[idx]);
      checkOutput($sformatf("vec%0d", idx), vecs[idx]);
    end

    // Frozen pipeline: several cycles of rdy low with a call pending must
    // neither move the PC nor push the stack
    for (int c = 0; c < 3; c++) begin
      applyStimulus(mk(0, 0, 0, 0, 32'h0, 1, 1, 0, 32'h800, 32'h20,
                       32'h0, 0, 2'b11, 1));
      checkOutput($sformatf("freeze%0d", c),
                  mk(0, 0, 0, 0, 32'h0, 1, 1, 0, 32'h800, 32'h20, 32'h0, 0, 2'b11, 1));
    end
    applyStimulus(mk(0, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h8, 0, 2'b11, 1));
    checkOutput("thaw", mk(0, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h8, 0, 2'b11, 1));
    applyStimulus(mk(0, 1, 0, 0, 32'h0, 1, 0, 1, 32'hA00, 32'h0, 32'hA00, 1, 2'b11, 1));
    checkOutput("thaw_ret", mk(0, 1, 0, 0, 32'h0, 1, 0, 1, 32'hA00, 32'h0, 32'hA00, 1, 2'b11, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
